// File: rtl/line_fifo.sv
// line_fifo: single-clock pixel FIFO between the fill engine and scan-out.
//
// Stores 2^addr_width words of data_width bits in an inferred RAM. The RAM
// itself is never reset. Pointers, level, q, q_valid and the error flags are
// reset asynchronously.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of pointers, level and q_valid
//   wr_en, d     write request and write data
//   rd_en        read request
//   q, q_valid   registered read data; q_valid marks a read accepted last cycle
//   level        occupancy, 0..2^addr_width
//   empty, full, almost_full, almost_empty   flags decoded from level
//   overflow     sticky: a write was rejected because the FIFO was full
//   underflow    sticky: a read was rejected because the FIFO was empty
//   err_clr      synchronous clear of overflow and underflow
module line_fifo #(
  parameter int unsigned data_width   = 8,
  parameter int unsigned addr_width   = 10,
  parameter int unsigned afull_level  = 1000,
  parameter int unsigned aempty_level = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [data_width-1:0] d,
  input  logic                  rd_en,
  output logic [data_width-1:0] q,
  output logic                  q_valid,
  output logic [addr_width:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned depth = 1 << addr_width;

  // Elaboration-time legality check on the threshold parameters.
  if (afull_level > depth || aempty_level >= depth) begin : g_param_check
    $fatal(1, "line_fifo: afull_level must be <= depth and aempty_level < depth");
  end

  localparam logic [addr_width:0] depth_lvl  = (addr_width + 1)'(depth);
  localparam logic [addr_width:0] afull_lvl  = (addr_width + 1)'(afull_level);
  localparam logic [addr_width:0] aempty_lvl = (addr_width + 1)'(aempty_level);

  logic [data_width-1:0] mem [depth];

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   level_q, level_d;
  logic [data_width-1:0] q_q;
  logic                  q_valid_q, q_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Flags come only from registered level, never from same-cycle requests.
  assign empty        = (level_q == '0);
  assign full         = (level_q == depth_lvl);
  assign almost_full  = (level_q >= afull_lvl);
  assign almost_empty = (level_q <= aempty_lvl);

  // flush overrides any same-cycle request.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    q_valid_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      // q and error flags are intentionally left untouched.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        q_valid_d = 1'b1;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      // Clearing wins over a set in the same cycle.
      if (err_clr) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (wr_en && full) begin
          overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      q_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      q_valid_q   <= q_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= d;
    end
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (rd_acc) begin
      q_q <= mem[rd_ptr_q];
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
